// File: rtl/pin_test_pattern_gen_if.sv
// Pattern-generator bus: pattern controls in, test pins and status pulses out.
//   mode          3-bit pattern select (0 DIV, 1 WALK1, 2 WALK0, 3 ID, 4 STATIC)
//   static_level  level driven on all pins in STATIC mode
//   pins          NUM_PINS registered test outputs
//   step_tick     one-clock pulse at each step boundary
//   frame_sync    one-clock pulse on the first bit of each ID frame
//   sweep_done    one-clock pulse when the walking position wraps
//   heartbeat     slow divider MSB for an LED
// master: the side that selects the pattern; slave: the generator.
interface pin_test_pattern_gen_if #(
  parameter int NUM_PINS = 64
);
  logic [2:0]          mode;
  logic                static_level;
  logic [NUM_PINS-1:0] pins;
  logic                step_tick;
  logic                frame_sync;
  logic                sweep_done;
  logic                heartbeat;

  modport master (
    output mode, static_level,
    input  pins, step_tick, frame_sync, sweep_done, heartbeat
  );

  modport slave (
    input  mode, static_level,
    output pins, step_tick, frame_sync, sweep_done, heartbeat
  );
endinterface

// File: rtl/pin_test_pattern_gen.sv
// Board-wiring test pattern generator. Drives NUM_PINS outputs with divider
// taps, a walking one/zero, per-pin serial ID frames, or a static level.
// Ports:
//   _125MHZ  system clock
//   nRESET   asynchronous active-low reset
//   bus      pin_test_pattern_gen_if.slave (mode/static_level in;
//            pins, step_tick, frame_sync, sweep_done, heartbeat out)
// The active pattern only changes on a step tick so a scope trace always
// starts on a clean step boundary; STATIC follows static_level every clock.
module pin_test_pattern_gen #(
  parameter int NUM_PINS  = 64,
  parameter int DIV_WIDTH = 28,
  parameter int TAP_BASE  = 6,
  parameter int STEP_DIV  = 12500000,
  parameter int IDW       = 8
) (
  input logic                  _125MHZ,
  input logic                  nRESET,
  pin_test_pattern_gen_if.slave bus
);

  localparam int FRAME_LEN   = IDW + 5;
  localparam int POS_W       = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam int BIT_W       = $clog2(FRAME_LEN);
  localparam int FRAME_SLOTS = 1 << BIT_W;
  localparam int PRESC_W     = $clog2(STEP_DIV);

  typedef enum logic [2:0] {
    MODE_DIV    = 3'd0,
    MODE_WALK1  = 3'd1,
    MODE_WALK0  = 3'd2,
    MODE_ID     = 3'd3,
    MODE_STATIC = 3'd4,
    MODE_RSV5   = 3'd5,
    MODE_RSV6   = 3'd6,
    MODE_RSV7   = 3'd7
  } mode_e;

  // Frame slot b holds the bit sent during bit period b:
  // 1, 0, id MSB..LSB, even parity, 0, 0. Unused slots stay 0.
  function automatic logic [FRAME_SLOTS-1:0] id_frame(input logic [IDW-1:0] id);
    logic [FRAME_SLOTS-1:0] f;
    f    = '0;
    f[0] = 1'b1;
    for (int b = 0; b < IDW; b++) begin
      f[2+b] = id[IDW-1-b];
    end
    f[IDW+2] = ^id;
    return f;
  endfunction

  logic [DIV_WIDTH-1:0] div_cnt_reg, div_cnt_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [2:0]           mode_q_reg, mode_q_next;
  mode_e                active_reg, active_next;
  logic [POS_W-1:0]     pos_reg, pos_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [NUM_PINS-1:0]  pins_reg, pins_next;
  logic                 step_tick_reg, step_tick_next;
  logic                 frame_sync_reg, frame_sync_next;
  logic                 sweep_done_reg, sweep_done_next;

  logic                 tick;
  logic                 mode_changed;
  logic                 walk_wrap;
  logic [NUM_PINS-1:0]  div_tap;
  logic [NUM_PINS-1:0]  id_bits;
  logic [NUM_PINS-1:0]  walk_onehot;

  // Per-pin divider tap and ID frame bit for the upcoming bit period.
  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    logic [FRAME_SLOTS-1:0] frame_bits;
    assign frame_bits  = id_frame(IDW'(gi));
    assign div_tap[gi] = div_cnt_reg[(TAP_BASE + gi) % DIV_WIDTH];
    assign id_bits[gi] = frame_bits[bit_next];
  end

  assign walk_onehot = NUM_PINS'(1) << pos_next;

  always_ff @(posedge _125MHZ or negedge nRESET) begin
    if (!nRESET) begin
      div_cnt_reg    <= '0;
      presc_reg      <= '0;
      mode_q_reg     <= '0;
      active_reg     <= MODE_DIV;
      pos_reg        <= '0;
      bit_reg        <= '0;
      pins_reg       <= '0;
      step_tick_reg  <= 1'b0;
      frame_sync_reg <= 1'b0;
      sweep_done_reg <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      presc_reg      <= presc_next;
      mode_q_reg     <= mode_q_next;
      active_reg     <= active_next;
      pos_reg        <= pos_next;
      bit_reg        <= bit_next;
      pins_reg       <= pins_next;
      step_tick_reg  <= step_tick_next;
      frame_sync_reg <= frame_sync_next;
      sweep_done_reg <= sweep_done_next;
    end
  end

  // Counters and active-mode state. The tick edge is the edge on which the
  // step_tick register rises, so every tick-driven change lands on the pins
  // in the same cycle the pulse is visible.
  always_comb begin
    tick         = (presc_reg == PRESC_W'(STEP_DIV - 1));
    div_cnt_next = div_cnt_reg + DIV_WIDTH'(1);
    presc_next   = tick ? '0 : presc_reg + PRESC_W'(1);
    mode_q_next  = bus.mode;
    active_next  = active_reg;
    pos_next     = pos_reg;
    bit_next     = bit_reg;
    mode_changed = 1'b0;
    walk_wrap    = 1'b0;
    if (tick) begin
      active_next  = mode_e'(mode_q_reg);
      mode_changed = (active_next != active_reg);
      if (mode_changed) begin
        // New pattern always starts from position 0 / frame bit 0.
        pos_next = '0;
        bit_next = '0;
      end else begin
        walk_wrap = (pos_reg == POS_W'(NUM_PINS - 1));
        pos_next  = walk_wrap ? '0 : pos_reg + POS_W'(1);
        bit_next  = (bit_reg == BIT_W'(FRAME_LEN - 1)) ? '0 : bit_reg + BIT_W'(1);
      end
    end
  end

  // Registered outputs, computed from the post-tick state.
  always_comb begin
    step_tick_next  = tick;
    sweep_done_next = walk_wrap &&
                      ((active_next == MODE_WALK1) || (active_next == MODE_WALK0));
    frame_sync_next = tick && (active_next == MODE_ID) && (bit_next == '0);
    pins_next       = '0;
    case (active_next)
      MODE_DIV:    pins_next = div_tap;
      MODE_WALK1:  pins_next = walk_onehot;
      MODE_WALK0:  pins_next = ~walk_onehot;
      MODE_ID:     pins_next = id_bits;
      MODE_STATIC: pins_next = {NUM_PINS{bus.static_level}};
      default:     pins_next = '0;
    endcase
  end

  assign bus.pins       = pins_reg;
  assign bus.step_tick  = step_tick_reg;
  assign bus.frame_sync = frame_sync_reg;
  assign bus.sweep_done = sweep_done_reg;
  assign bus.heartbeat  = div_cnt_reg[DIV_WIDTH-1];

endmodule

// File: tb/tb_pin_test_pattern_gen.sv
// Testbench for pin_test_pattern_gen with NUM_PINS=8, DIV_WIDTH=8,
// TAP_BASE=2, STEP_DIV=4, IDW=3. A cycle-count based reference model
// predicts every output after each clock edge.
module tb_pin_test_pattern_gen;
  localparam int NP = 8;
  localparam int DW = 8;
  localparam int TB = 2;
  localparam int SD = 4;
  localparam int IW = 3;
  localparam int F  = IW + 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pin_test_pattern_gen_if #(.NUM_PINS(NP)) bus ();

  pin_test_pattern_gen #(
    .NUM_PINS (NP),
    .DIV_WIDTH(DW),
    .TAP_BASE (TB),
    .STEP_DIV (SD),
    .IDW      (IW)
  ) dut (
    ._125MHZ(clk),
    .nRESET (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since release, sampled mode, active mode,
  // walk position, frame bit index.
  int k, mq, act, pos, bitn;
  logic [7:0] e_pins;
  logic       e_step, e_frame, e_sweep, e_hb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic id_bit(input int i, input int b);
    logic [2:0] id;
    id = i[2:0];
    if (b == 0) return 1'b1;
    if (b >= 2 && b < 2 + IW) return id[IW-1-(b-2)];
    if (b == 2 + IW) return logic'($countones(id) % 2);
    return 1'b0;
  endfunction

  task automatic model_reset();
    k = 0; mq = 0; act = 0; pos = 0; bitn = 0;
    e_pins = '0; e_step = 0; e_frame = 0; e_sweep = 0; e_hb = 0;
  endtask

  task automatic model_edge();
    logic [7:0] olddiv;
    logic [7:0] one;
    int  nm;
    bit  tk, ch, wrap;
    one    = 8'd1;
    olddiv = 8'(k % 256);
    k++;
    tk = (k % SD == 0);
    nm = mq;
    mq = int'(bus.mode);
    ch = 0;
    wrap = 0;
    if (tk) begin
      ch  = (nm != act);
      act = nm;
      if (ch) begin
        pos = 0; bitn = 0;
      end else begin
        wrap = (pos == NP - 1);
        pos  = (pos + 1) % NP;
        bitn = (bitn + 1) % F;
      end
    end
    e_step  = tk;
    e_sweep = wrap && (act == 1 || act == 2);
    e_frame = tk && act == 3 && bitn == 0;
    e_hb    = logic'(((k % 256) >> 7) & 1);
    e_pins  = '0;
    case (act)
      0: for (int i = 0; i < NP; i++) e_pins[i] = olddiv[(TB + i) % DW];
      1: e_pins = one << pos;
      2: e_pins = ~(one << pos);
      3: for (int i = 0; i < NP; i++) e_pins[i] = id_bit(i, bitn);
      4: e_pins = {NP{bus.static_level}};
      default: e_pins = '0;
    endcase
  endtask

  task automatic check_all();
    chk("pins", 64'(bus.pins), 64'(e_pins));
    chk("step_tick", 64'(bus.step_tick), 64'(e_step));
    chk("frame_sync", 64'(bus.frame_sync), 64'(e_frame));
    chk("sweep_done", 64'(bus.sweep_done), 64'(e_sweep));
    chk("heartbeat", 64'(bus.heartbeat), 64'(e_hb));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (e_step)
      $display("tick t=%0t mode=%0d pins=%h frame_sync=%b sweep_done=%b",
               $time, act, bus.pins, bus.frame_sync, bus.sweep_done);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cyc();
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int         got;
    bit         reached;
    logic [7:0] s5, s3;

    bus.mode         = 3'd0;
    bus.static_level = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk); #1; check_all();

    // 1: DIV taps after release
    release_reset();
    run(40);

    // 2: WALK1 from reset
    bus.mode = 3'd1;
    async_reset();
    release_reset();
    run(40);

    // 3: WALK0
    bus.mode = 3'd2;
    run(40);

    // 4: ID frames, capture pin 5 and pin 3 over one frame
    bus.mode = 3'd3;
    got = 0; s5 = '0; s3 = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      cyc();
      if (e_step && (got > 0 || e_frame)) begin
        s5 = {s5[6:0], bus.pins[5]};
        s3 = {s3[6:0], bus.pins[3]};
        got++;
      end
    end
    chk("id_pin5_seq", 64'(s5), 64'(8'b10101000));
    chk("id_pin3_seq", 64'(s3), 64'(8'b10011000));
    run(20);

    // 5: switch WALK1 -> ID at pos 5, then back to WALK1
    bus.mode = 3'd1;
    reached = 0;
    for (int c = 0; c < 100 && !reached; c++) begin
      cyc();
      if (e_step && act == 1 && pos == 5) reached = 1;
    end
    chk("reach_pos5", 64'(reached), 64'(1));
    bus.mode = 3'd3;
    run(24);
    bus.mode = 3'd1;
    run(24);

    // 6: reset mid ID frame, STATIC high, then reserved mode
    bus.mode = 3'd3;
    run(14);
    bus.mode         = 3'd4;
    bus.static_level = 1'b1;
    async_reset();
    release_reset();
    run(12);
    bus.static_level = 1'b0;
    run(3);
    bus.static_level = 1'b1;
    run(3);
    bus.mode = 3'd6;
    run(20);

    // Randomised mode and level changes with one reset mid-run
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        async_reset();
        release_reset();
      end
      cyc();
      if ($urandom_range(0, 9) == 0) bus.mode = 3'($urandom_range(0, 7));
      bus.static_level = 1'($urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
